// File: rtl/div_norm_if.sv
// Operand/result bundle for the divider normalizer: numerator/denominator in,
// normalized operands + shift count + divide-by-zero flag out, valid/ready on both sides.
// master = producer of operands / consumer of results; slave = the normalizer itself.
interface div_norm_if #(
  parameter int W  = 8,
  parameter int SW = 3
) ();
  logic [W-1:0]  n_in;
  logic [W-1:0]  d_in;
  logic          in_valid;
  logic          in_ready;
  logic [W:0]    n_out;
  logic [W:0]    d_out;
  logic [SW-1:0] shift_out;
  logic          dz_out;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output n_in, d_in, in_valid, out_ready,
    input  in_ready, n_out, d_out, shift_out, dz_out, out_valid
  );

  modport slave (
    input  n_in, d_in, in_valid, out_ready,
    output in_ready, n_out, d_out, shift_out, dz_out, out_valid
  );
endinterface

// File: rtl/div_norm.sv
// Purpose: normalizes the denominator (MSB set) ahead of the convergence divider, reports shift count.
// Latency: s+1 cycles from accept to out_valid (s = shifts); 1 cycle with DIV_NORM_FAST_EN.
// Backpressure: outputs held while out_ready=0; in_ready only in IDLE, no same-cycle re-accept.
//
// Ports: clk, reset (sync, active-high), bus (div_norm_if.slave):
//   n_in/d_in/in_valid/in_ready   - raw operand pair handshake
//   n_out/d_out/shift_out/dz_out  - zero-extended W+1-bit operands, shift count, d==0 flag
//   out_valid/out_ready           - result handshake
// Build option: define DIV_NORM_FAST_EN to replace the one-shift-per-cycle loop with a
// leading-zero count plus barrel shift (single NORM cycle, identical outputs).
module div_norm #(
  parameter int W  = 8,
  parameter int SW = 3
) (
  input logic       clk,
  input logic       reset,
  div_norm_if.slave bus
);

  typedef enum logic [1:0] {IDLE, NORM, OUT} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  n_reg, d_reg;
  logic          d_zero;
  logic          norm_done;
  logic [W-1:0]  d_norm;
  logic [SW-1:0] shift_norm;
  logic          load_in, load_out, release_out;

  assign d_zero       = (d_reg == '0);
  assign bus.in_ready = (state == IDLE);

`ifdef DIV_NORM_FAST_EN
  // Leading-zero count of a nonzero value; the d==0 case is masked by the caller.
  function automatic logic [SW-1:0] lzc(input logic [W-1:0] v);
    logic [SW-1:0] c;
    logic          found;
    c     = '0;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      c     = c + 1'b1;
      end
    end
    return c;
  endfunction

  assign shift_norm = d_zero ? '0 : lzc(d_reg);
  assign d_norm     = d_reg << shift_norm;
  assign norm_done  = 1'b1;
`else
  logic [SW-1:0] cnt;

  assign shift_norm = cnt;
  assign d_norm     = d_reg;
  // A zero denominator never gains an MSB, so it terminates immediately with cnt=0.
  assign norm_done  = d_zero | d_reg[W-1];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and control strobes
  always_comb begin
    state_nxt   = state;
    load_in     = 1'b0;
    load_out    = 1'b0;
    release_out = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          load_in   = 1'b1;
          state_nxt = NORM;
        end
      end
      NORM: begin
        if (norm_done) begin
          load_out  = 1'b1;
          state_nxt = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          release_out = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand registers; in iterative mode d_reg is shifted in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_reg <= '0;
      d_reg <= '0;
    end else if (load_in) begin
      n_reg <= bus.n_in;
      d_reg <= bus.d_in;
    end
`ifndef DIV_NORM_FAST_EN
    else if (state == NORM && !norm_done) begin
      d_reg <= d_reg << 1;
    end
`endif
  end

`ifndef DIV_NORM_FAST_EN
  always_ff @(posedge clk) begin
    if (reset)                            cnt <= '0;
    else if (load_in)                     cnt <= '0;
    else if (state == NORM && !norm_done) cnt <= cnt + 1'b1;
  end
`endif

  // Result registers: data keeps its last value after release, only out_valid drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.n_out     <= '0;
      bus.d_out     <= '0;
      bus.shift_out <= '0;
      bus.dz_out    <= 1'b0;
      bus.out_valid <= 1'b0;
    end else if (load_out) begin
      bus.n_out     <= {1'b0, n_reg};
      bus.d_out     <= {1'b0, d_norm};
      bus.shift_out <= shift_norm;
      bus.dz_out    <= d_zero;
      bus.out_valid <= 1'b1;
    end else if (release_out) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_norm.sv
// Directed bench for div_norm: reset state, normalization values, latency,
// backpressure hold, ignored input during OUT, mid-operation reset, full d sweep.
module tb_div_norm;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  div_norm_if #(.W(8), .SW(3)) bus ();

  div_norm #(.W(8), .SW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat_of(input int s);
`ifdef DIV_NORM_FAST_EN
    return 1;
`else
    return s + 1;
`endif
  endfunction

  // Sends one pair, checks latency and results, optionally holds out_ready low
  // for 'hold' cycles (with a stray in_valid pulse), then releases the result.
  task automatic run_pair(input string tag, input logic [7:0] n, input logic [7:0] d,
                          input logic [8:0] exp_d, input int exp_sh, input int hold);
    int lat;
    int irhi;
    int changes;
    chk({tag, ".in_ready_pre"}, 32'(bus.in_ready), 32'd1);
    bus.n_in     = n;
    bus.d_in     = d;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.n_in     = 8'hEE;
    bus.d_in     = 8'h0E;
    lat  = 0;
    irhi = 0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) irhi++;
      step();
      lat++;
    end
    chk({tag, ".latency"},   32'(lat),           32'(lat_of(exp_sh)));
    chk({tag, ".in_ready_busy"}, 32'(irhi),       32'd0);
    chk({tag, ".n_out"},     32'(bus.n_out),     32'({1'b0, n}));
    chk({tag, ".d_out"},     32'(bus.d_out),     32'(exp_d));
    chk({tag, ".shift_out"}, 32'(bus.shift_out), 32'(exp_sh));
    chk({tag, ".dz_out"},    32'(bus.dz_out),    32'(d == 8'h00));
    changes = 0;
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        bus.n_in     = 8'hAA;
        bus.d_in     = 8'h03;
        bus.in_valid = 1'b1;
      end
      step();
      bus.in_valid = 1'b0;
      if (bus.out_valid !== 1'b1 || bus.d_out !== exp_d || bus.shift_out !== 3'(exp_sh) ||
          bus.n_out !== {1'b0, n} || bus.in_ready !== 1'b0)
        changes++;
    end
    if (hold > 0) chk({tag, ".hold_stable"}, 32'(changes), 32'd0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, ".out_valid_rel"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".in_ready_rel"},  32'(bus.in_ready),  32'd1);
    chk({tag, ".d_out_kept"},    32'(bus.d_out),     32'(exp_d));
    step();
    chk({tag, ".no_stray"},      32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int seen;
    int s;
    logic [7:0] v;
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.n_in      = 8'h00;
    bus.d_in      = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset dominates a valid input in the same cycle.
    bus.in_valid = 1'b1;
    bus.d_in     = 8'h01;
    step();
    step();
    chk("rst.in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.n_out",     32'(bus.n_out),     32'd0);
    chk("rst.d_out",     32'(bus.d_out),     32'd0);
    chk("rst.shift_out", 32'(bus.shift_out), 32'd0);
    chk("rst.dz_out",    32'(bus.dz_out),    32'd0);
    bus.in_valid = 1'b0;
    bus.d_in     = 8'h00;
    reset        = 1'b0;
    step();

    run_pair("t1_msb_set", 8'h64, 8'h80, 9'h080, 0, 0);
    run_pair("t2_d1",      8'h03, 8'h01, 9'h080, 7, 0);
    run_pair("t3_dz",      8'h55, 8'h00, 9'h000, 0, 0);
    run_pair("t4_bp",      8'h11, 8'h05, 9'h0A0, 5, 6);

    // Reset two cycles after accepting d=1: the pair must vanish.
    bus.n_in     = 8'h07;
    bus.d_in     = 8'h01;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (bus.out_valid) seen++;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5.in_ready",  32'(bus.in_ready),  32'd1);
    chk("t5.out_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.out_valid) seen++;
    end
`ifdef DIV_NORM_FAST_EN
    // Single-cycle mode finishes before the reset, so exactly one valid cycle run is seen.
    chk("t5.valid_seen", 32'(seen), 32'd2);
`else
    chk("t5.valid_seen", 32'(seen), 32'd0);
`endif
    run_pair("t5_after", 8'h22, 8'h40, 9'h080, 1, 0);

    // Full denominator sweep against a shift-until-MSB model.
    for (int d = 0; d < 256; d++) begin
      v = 8'(d);
      s = 0;
      if (v != 8'h00) begin
        while (!v[7]) begin
          v = v << 1;
          s++;
        end
      end
      run_pair($sformatf("sweep_d%0d", d), 8'(d) ^ 8'h5A, 8'(d), {1'b0, v}, s, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
